mask_fetch_ctrl: RTL and testbench
==================================

Name: mask_fetch_ctrl

Overview:
- Sequences the single-port pixel BRAM (24-bit RGB words, 1-cycle registered read gated by `re`) to build a 3x3 neighbourhood window for every pixel of a WIDTH x HEIGHT frame, in raster order.
- Sits between the frame BRAM and the downstream mask/filter stage, and owns the BRAM port while busy.
- Emits one window per pixel over a valid/ready handshake.

Parameters:
- WIDTH, 205, image width in pixels
- HEIGHT, 308, image height in pixels (WIDTH*HEIGHT = 63140)
- ADDR_WIDTH, 16, BRAM address width; 2^ADDR_WIDTH >= WIDTH*HEIGHT
- PIX_W, 24, pixel width (3 x 8-bit RGB columns)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame scan; sampled only in IDLE
- busy  out  1  high from start accepted until done
- done  out  1  one-cycle pulse after the last window is accepted
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_re  out  1  BRAM read enable
- bram_we  out  3  BRAM byte write enables; constant 3'b000
- bram_do  in  PIX_W  BRAM read data, valid the cycle after bram_re
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts window
- win_data  out  9*PIX_W  packed window; slot k at [k*PIX_W +: PIX_W], k=0..8 = tl,tc,tr,l,c,r,bl,bc,br
- win_x  out  16  column of centre pixel
- win_y  out  16  row of centre pixel
- win_edge  out  1  centre pixel lies on the frame border

Behaviour:
- Reset: state IDLE; busy, done, bram_re, win_valid, win_edge = 0; bram_addr, win_data, win_x, win_y = 0.
- FSM states:
  - IDLE: start=1 -> ISSUE, x=y=0, base=0, busy=1.
  - ISSUE: one read per cycle (bram_re=1); k steps through the read list.
  - WAIT: captures the final read data.
  - OUT: win_valid=1, held stable until win_ready.
  - On accept: advance x (wrap to 0 at WIDTH-1, y++); base++. Go to ISSUE, or to IDLE with done=1 after pixel (WIDTH-1, HEIGHT-1).
- Address generation: base = y*WIDTH+x via an incrementing counter, no multiplier. Slot addresses are base-WIDTH-1, base-WIDTH, base-WIDTH+1, base-1, base, base+1, base+WIDTH-1, base+WIDTH, base+WIDTH+1.
- Interior pixel (0<x<WIDTH-1, 0<y<HEIGHT-1): 9 reads, slots 0..8 in order.
- Edge pixel: only slot 4 is read. The other 8 slots are 0. win_edge=1. No out-of-range address is ever driven.
- Capture: data for the read issued in cycle c is written into its slot at the end of cycle c+1.
- Latency: start sampled in cycle t.
  - Interior: reads t+1..t+9, win_valid from cycle t+11.
  - Edge: read t+1, win_valid from cycle t+3.
  - For subsequent pixels the same counts apply from the accept cycle.
- win_data, win_x, win_y, win_edge are stable while win_valid=1 and win_ready=0.
- bram_re=0 in IDLE, WAIT and OUT. bram_addr holds its last value when not reading.
- start while busy: ignored. win_ready while !win_valid: ignored.
- rst mid-frame: abort immediately. All outputs return to reset values on the next edge. No done pulse.
- done and the accept of the last window: done is asserted in the cycle after that accept, with busy falling in the same cycle.

Optional Feature:
- Macro: MASK_EDGE_REPLICATE_EN.
- Defined: for edge pixels, all 8 non-centre slots carry the centre pixel value instead of 0. Still exactly one BRAM read and the same latency.
- Undefined: non-centre slots of edge pixels are zero.

Test Plan:
- Bench setup for all scenarios: WIDTH=4, HEIGHT=3, BRAM model preloaded with RAM[a] = {8'h00, a[15:0]}, win_ready tied 1.
- start at t=0 -> pixel (0,0): win_edge=1, slot4=24'h000000, other slots 0, win_valid at t=3; exactly 12 windows; done pulses once after window (3,2).
- Interior window (x=1, y=1) -> slots = 0,1,2,4,5,6,8,9,10 (24'h00000N); 9 consecutive bram_re cycles with those addresses in that order; win_valid 10 cycles after the first read.
- win_ready held 0 for 5 cycles on window (2,1) -> win_valid stays 1, win_data = 1,2,3,5,6,7,9,10,11 unchanged; no bram_re during stall.
- rst pulsed 1 cycle during the ISSUE of pixel (1,1) -> next cycle busy=0, bram_re=0, win_valid=0, no done. A new start re-runs from (0,0) with identical results.
- start held high for the whole frame and during busy -> only one frame runs. bram_we==3'b000 throughout.
- With MASK_EDGE_REPLICATE_EN defined: pixel (3,0) -> all 9 slots = 24'h000003; pixel (1,1) unchanged from the interior case.

Source files
------------

// File: rtl/mask_fetch_ctrl.sv
// mask_fetch_ctrl: walks a WIDTH x HEIGHT frame in raster order and, for each
// pixel, reads its 3x3 neighbourhood from a single-port pixel BRAM into a
// packed window that is handed downstream over a valid/ready handshake.
// Interior pixels take nine reads (tl..br); border pixels take one read of
// the centre only.
// Optional build macro MASK_EDGE_REPLICATE_EN: when defined, border windows
// carry the centre pixel in all nine slots instead of zeros in the other eight.
module mask_fetch_ctrl #(
    parameter int WIDTH      = 205,
    parameter int HEIGHT     = 308,
    parameter int ADDR_WIDTH = 16,
    parameter int PIX_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_re,
    output logic [2:0]            bram_we,
    input  logic [PIX_W-1:0]      bram_do,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [9*PIX_W-1:0]    win_data,
    output logic [15:0]           win_x,
    output logic [15:0]           win_y,
    output logic                  win_edge
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam logic [15:0]           X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0]           Y_LAST = 16'(HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] W_P1_A = ADDR_WIDTH'(WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] W_M2_A = ADDR_WIDTH'(WIDTH - 2);

    state_t                  state_q;
    logic                    busy_q, done_q, re_q, valid_q, edge_q;
    logic [ADDR_WIDTH-1:0]   addr_q, base_q;
    logic [15:0]             x_q, y_q;
    logic [3:0]              k_q;
    logic                    cap_vld_q;
    logic [3:0]              cap_slot_q;
    logic [9*PIX_W-1:0]      data_q;

    logic [15:0]             nx_d, ny_d;
    logic                    nedge_d, last_pix_d, last_rd_d;
    logic [ADDR_WIDTH-1:0]   nbase_d, nfirst_d, nstep_d;

    // Window contents for a border pixel, built from the single centre read.
    function automatic logic [9*PIX_W-1:0] edge_fill(input logic [PIX_W-1:0] c);
`ifdef MASK_EDGE_REPLICATE_EN
        return {9{c}};
`else
        logic [9*PIX_W-1:0] w;
        w = '0;
        w[4*PIX_W +: PIX_W] = c;
        return w;
`endif
    endfunction

    // Next-pixel coordinates, first read address and in-window address stepping.
    always_comb begin
        last_pix_d = (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
            nx_d = '0;
            ny_d = y_q + 16'd1;
        end else begin
            nx_d = x_q + 16'd1;
            ny_d = y_q;
        end
        nedge_d  = (nx_d == '0) || (nx_d == X_LAST) || (ny_d == '0) || (ny_d == Y_LAST);
        nbase_d  = base_q + ONE_A;
        // Interior windows start at the top-left neighbour; border windows read only the centre.
        nfirst_d = nedge_d ? nbase_d : (nbase_d - W_P1_A);
        last_rd_d = edge_q || (k_q == 4'd8);
        // After the right column of a row, jump to the left column of the next row.
        nstep_d  = ((k_q == 4'd2) || (k_q == 4'd5)) ? (addr_q + W_M2_A) : (addr_q + ONE_A);
    end

    // Frame-scan FSM with read issue, one-cycle-late capture and output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            re_q       <= 1'b0;
            valid_q    <= 1'b0;
            edge_q     <= 1'b0;
            addr_q     <= '0;
            base_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
            data_q     <= '0;
        end else begin
            done_q     <= 1'b0;
            // BRAM data arrives the cycle after the read; remember which slot it belongs to.
            cap_vld_q  <= re_q;
            cap_slot_q <= k_q;
            if (cap_vld_q) begin
                if (edge_q) begin
                    data_q <= edge_fill(bram_do);
                end else begin
                    for (int s = 0; s < 9; s++) begin
                        if (cap_slot_q == 4'(s)) data_q[s*PIX_W +: PIX_W] <= bram_do;
                    end
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        re_q    <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                        base_q  <= '0;
                        addr_q  <= '0;
                        edge_q  <= 1'b1;
                        k_q     <= 4'd4;
                    end
                end
                ISSUE: begin
                    if (last_rd_d) begin
                        state_q <= WAIT;
                        re_q    <= 1'b0;
                    end else begin
                        k_q    <= k_q + 4'd1;
                        addr_q <= nstep_d;
                    end
                end
                WAIT: begin
                    state_q <= OUT;
                    valid_q <= 1'b1;
                end
                OUT: begin
                    if (win_ready) begin
                        valid_q <= 1'b0;
                        if (last_pix_d) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            re_q    <= 1'b1;
                            x_q     <= nx_d;
                            y_q     <= ny_d;
                            base_q  <= nbase_d;
                            edge_q  <= nedge_d;
                            addr_q  <= nfirst_d;
                            k_q     <= nedge_d ? 4'd4 : 4'd0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bram_addr = addr_q;
    assign bram_re   = re_q;
    assign bram_we   = 3'b000;
    assign win_valid = valid_q;
    assign win_data  = data_q;
    assign win_x     = x_q;
    assign win_y     = y_q;
    assign win_edge  = edge_q;

endmodule

// File: tb/tb_mask_fetch_ctrl.sv
// Bench for mask_fetch_ctrl on a 4x3 frame with a BRAM model holding
// RAM[a] = {8'h00, a}. Expected windows are queued when a frame is started
// and popped as the DUT hands them over.
module tb_mask_fetch_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        logic [15:0]  x;
        logic [15:0]  y;
        logic         edg;
        logic [215:0] data;
    } win_t;

    logic         clk, rst, start, win_ready;
    logic         busy, done, bram_re, win_valid, win_edge;
    logic [15:0]  bram_addr, win_x, win_y;
    logic [2:0]   bram_we;
    logic [23:0]  bram_do;
    logic [215:0] win_data;

    int   n_cmp, n_bad;
    win_t exp_q[$];

    mask_fetch_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(16), .PIX_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .bram_addr(bram_addr), .bram_re(bram_re), .bram_we(bram_we), .bram_do(bram_do),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_x(win_x), .win_y(win_y), .win_edge(win_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bram_re) bram_do <= {8'h00, bram_addr};

    function automatic logic [23:0] pix(input int a);
        return {8'h00, 16'(a)};
    endfunction

    task automatic push_frame();
        win_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.x = 16'(x);
                e.y = 16'(y);
                e.edg = (x == 0) || (x == W-1) || (y == 0) || (y == H-1);
                e.data = '0;
                if (e.edg) begin
`ifdef MASK_EDGE_REPLICATE_EN
                    for (int k = 0; k < 9; k++) e.data[k*24 +: 24] = pix(y*W + x);
`else
                    e.data[4*24 +: 24] = pix(y*W + x);
`endif
                end else begin
                    for (int k = 0; k < 9; k++) e.data[k*24 +: 24] = pix((y-1+k/3)*W + (x-1+k%3));
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; win_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, bram_re, win_valid, win_edge, bram_addr, win_x, win_y, win_data, bram_we} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got busy=%b done=%b re=%b valid=%b edge=%b addr=%h x=%0d y=%0d data=%h we=%b, want all zero",
                     busy, done, bram_re, win_valid, win_edge, bram_addr, win_x, win_y, win_data, bram_we);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame();
        win_t e;
        int nwin = 0, ndone = 0, we_bad = 0, last_acc = -10, done_t = 0;
        exp_q.delete(); push_frame(); win_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t < 400; t++) begin
            @(negedge clk);
            if (t == 1) begin
                start = 1'b0;
                n_cmp++;
                if (bram_re !== 1'b1 || bram_addr !== 16'd0 || busy !== 1'b1) begin
                    n_bad++; $display("FAIL frame_first_read got re=%b addr=%0d busy=%b, want 1 0 1", bram_re, bram_addr, busy);
                end
            end
            if (t == 2) begin
                n_cmp++;
                if (win_valid !== 1'b0) begin n_bad++; $display("FAIL edge_early_valid got %b want 0", win_valid); end
            end
            if (t == 3) begin
                n_cmp++;
                if (win_valid !== 1'b1) begin n_bad++; $display("FAIL edge_latency valid got %b want 1 at t=3", win_valid); end
            end
            if (bram_we !== 3'b000) we_bad++;
            if (done === 1'b1) begin
                ndone++; done_t = t;
                n_cmp++;
                if (last_acc != t-1 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL done_timing got done at t=%0d busy=%b, want t=%0d busy=0", t, busy, last_acc+1);
                end
            end
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                nwin++; n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL frame_win got extra window (%0d,%0d), want none", win_x, win_y);
                end else begin
                    e = exp_q.pop_front();
                    if (e.x == 16'(W-1) && e.y == 16'(H-1)) last_acc = t;
                    if ({win_x, win_y, win_edge, win_data} !== {e.x, e.y, e.edg, e.data}) begin
                        n_bad++;
                        $display("FAIL frame_win got (%0d,%0d) edge=%b data=%h, want (%0d,%0d) edge=%b data=%h",
                                 win_x, win_y, win_edge, win_data, e.x, e.y, e.edg, e.data);
                    end
                end
            end
            if (ndone > 0 && t >= done_t + 3) break;
        end
        n_cmp++;
        if (nwin != W*H || ndone != 1) begin
            n_bad++; $display("FAIL frame_count got windows=%0d dones=%0d, want %0d 1", nwin, ndone, W*H);
        end
        n_cmp++;
        if (we_bad != 0) begin n_bad++; $display("FAIL bram_we got %0d nonzero cycles, want 0", we_bad); end
    endtask

    task automatic test_interior();
        win_t e;
        int a = -1, nwin = 0, ndone = 0, ea;
        exp_q.delete(); push_frame(); win_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t < 400; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (a >= 0 && t > a && t <= a + 9) begin
                ea = ((t-a-1)/3)*W + ((t-a-1)%3);
                n_cmp++;
                if (bram_re !== 1'b1 || bram_addr !== 16'(ea)) begin
                    n_bad++; $display("FAIL int_read k=%0d got re=%b addr=%0d, want re=1 addr=%0d", t-a-1, bram_re, bram_addr, ea);
                end
            end
            if (a >= 0 && t == a + 10) begin
                n_cmp++;
                if (bram_re !== 1'b0 || win_valid !== 1'b0) begin
                    n_bad++; $display("FAIL int_wait got re=%b valid=%b, want 0 0", bram_re, win_valid);
                end
            end
            if (a >= 0 && t == a + 11) begin
                n_cmp++;
                if (win_valid !== 1'b1) begin n_bad++; $display("FAIL int_latency got valid=%b, want 1", win_valid); end
            end
            if (done === 1'b1) ndone++;
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                nwin++; n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL int_win got extra window (%0d,%0d), want none", win_x, win_y);
                end else begin
                    e = exp_q.pop_front();
                    if (e.x == 16'd0 && e.y == 16'd1) a = t;
                    if ({win_x, win_y, win_edge, win_data} !== {e.x, e.y, e.edg, e.data}) begin
                        n_bad++;
                        $display("FAIL int_win got (%0d,%0d) edge=%b data=%h, want (%0d,%0d) edge=%b data=%h",
                                 win_x, win_y, win_edge, win_data, e.x, e.y, e.edg, e.data);
                    end
                end
            end
            if (ndone > 0) break;
        end
        n_cmp++;
        if (a < 0 || nwin != W*H) begin n_bad++; $display("FAIL int_frame got windows=%0d, want %0d", nwin, W*H); end
    endtask

    task automatic test_stall();
        win_t e;
        int nwin = 0, ndone = 0, scnt = 0;
        bit stalled = 0;
        exp_q.delete(); push_frame(); win_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t < 400; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (stalled && win_ready === 1'b0 && scnt == 5) win_ready = 1'b1;
            if (!stalled && win_valid === 1'b1 && exp_q.size() > 0 && exp_q[0].x == 16'd2 && exp_q[0].y == 16'd1) begin
                stalled = 1; win_ready = 1'b0;
            end
            if (stalled && win_ready === 1'b0) begin
                n_cmp++;
                if (win_valid !== 1'b1 || bram_re !== 1'b0 || win_data !== exp_q[0].data || win_x !== 16'd2 || win_y !== 16'd1) begin
                    n_bad++;
                    $display("FAIL stall_hold cycle %0d got valid=%b re=%b (%0d,%0d) data=%h, want 1 0 (2,1) data=%h",
                             scnt, win_valid, bram_re, win_x, win_y, win_data, exp_q[0].data);
                end
                scnt++;
            end
            if (done === 1'b1) ndone++;
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                nwin++; n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stall_win got extra window (%0d,%0d), want none", win_x, win_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({win_x, win_y, win_edge, win_data} !== {e.x, e.y, e.edg, e.data}) begin
                        n_bad++;
                        $display("FAIL stall_win got (%0d,%0d) edge=%b data=%h, want (%0d,%0d) edge=%b data=%h",
                                 win_x, win_y, win_edge, win_data, e.x, e.y, e.edg, e.data);
                    end
                end
            end
            if (ndone > 0) break;
        end
        win_ready = 1'b1;
        n_cmp++;
        if (scnt != 5 || nwin != W*H || ndone != 1) begin
            n_bad++; $display("FAIL stall_frame got stall=%0d windows=%0d dones=%0d, want 5 %0d 1", scnt, nwin, ndone, W*H);
        end
    endtask

    task automatic test_reset_mid();
        win_t e;
        int nwin = 0, ndone = 0, bad_after = 0;
        bit found = 0;
        exp_q.delete(); push_frame(); win_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t < 200; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (win_valid === 1'b1 && win_ready === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); nwin++;
                if (e.x == 16'd0 && e.y == 16'd1) begin found = 1; break; end
            end
        end
        n_cmp++;
        if (!found || nwin != 5) begin n_bad++; $display("FAIL rstmid_reach got windows=%0d, want 5", nwin); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bram_re !== 1'b1) begin n_bad++; $display("FAIL rstmid_issue got re=%b, want 1", bram_re); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, bram_re, win_valid, win_edge, bram_addr, win_x, win_y, win_data} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_abort got busy=%b done=%b re=%b valid=%b edge=%b addr=%0d x=%0d y=%0d, want all zero",
                     busy, done, bram_re, win_valid, win_edge, bram_addr, win_x, win_y);
        end
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || bram_re !== 1'b0) bad_after++;
        end
        n_cmp++;
        if (bad_after != 0) begin n_bad++; $display("FAIL rstmid_quiet got %0d active cycles, want 0", bad_after); end
        exp_q.delete(); push_frame(); nwin = 0;
        start = 1'b1;
        for (int t = 1; t < 400; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (done === 1'b1) ndone++;
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                nwin++; n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rerun_win got extra window (%0d,%0d), want none", win_x, win_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({win_x, win_y, win_edge, win_data} !== {e.x, e.y, e.edg, e.data}) begin
                        n_bad++;
                        $display("FAIL rerun_win got (%0d,%0d) edge=%b data=%h, want (%0d,%0d) edge=%b data=%h",
                                 win_x, win_y, win_edge, win_data, e.x, e.y, e.edg, e.data);
                    end
                end
            end
            if (ndone > 0) break;
        end
        n_cmp++;
        if (nwin != W*H || ndone != 1) begin
            n_bad++; $display("FAIL rerun_count got windows=%0d dones=%0d, want %0d 1", nwin, ndone, W*H);
        end
    endtask

    task automatic test_start_held();
        win_t e;
        int nwin = 0, ndone = 0, busy_bad = 0, we_bad = 0;
        exp_q.delete(); push_frame(); win_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t < 400; t++) begin
            @(negedge clk);
            if (bram_we !== 3'b000) we_bad++;
            if (done === 1'b1) begin ndone++; start = 1'b0; end
            else if (busy !== 1'b1) busy_bad++;
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                nwin++; n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL held_win got extra window (%0d,%0d), want none", win_x, win_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({win_x, win_y, win_edge, win_data} !== {e.x, e.y, e.edg, e.data}) begin
                        n_bad++;
                        $display("FAIL held_win got (%0d,%0d) edge=%b data=%h, want (%0d,%0d) edge=%b data=%h",
                                 win_x, win_y, win_edge, win_data, e.x, e.y, e.edg, e.data);
                    end
                end
            end
            if (ndone > 0) break;
        end
        repeat (2) begin
            @(negedge clk);
            if (busy !== 1'b0 || bram_re !== 1'b0 || done !== 1'b0) busy_bad++;
        end
        n_cmp++;
        if (nwin != W*H || ndone != 1 || busy_bad != 0) begin
            n_bad++; $display("FAIL held_frame got windows=%0d dones=%0d busy_errs=%0d, want %0d 1 0", nwin, ndone, busy_bad, W*H);
        end
        n_cmp++;
        if (we_bad != 0) begin n_bad++; $display("FAIL held_we got %0d nonzero cycles, want 0", we_bad); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; win_ready = 1'b1;
        test_reset();
        test_frame();
        repeat (2) @(negedge clk);
        test_interior();
        repeat (2) @(negedge clk);
        test_stall();
        repeat (2) @(negedge clk);
        test_reset_mid();
        repeat (2) @(negedge clk);
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
